// File: rtl/stitch_pipe_pkg.sv
// Shared types and helpers for the stitched split-and-add pipeline.
package stitch_pipe_pkg;

    localparam int unsigned DEFAULT_W      = 32;
    localparam int unsigned DEFAULT_STAGES = 2;
    // Widest operand half the pack/unpack helpers can handle.
    localparam int unsigned W_MAX          = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Mask selecting the low w bits of a packed operand word.
    function automatic logic [2*W_MAX-1:0] half_mask(input int unsigned w);
        return {(2*W_MAX){1'b1}} >> (2*W_MAX - w);
    endfunction

    // Low half of a 2*w word is x.
    function automatic logic [W_MAX-1:0] unpack_x(input logic [2*W_MAX-1:0] word,
                                                  input int unsigned w);
        return W_MAX'(word & half_mask(w));
    endfunction

    // High half of a 2*w word is y.
    function automatic logic [W_MAX-1:0] unpack_y(input logic [2*W_MAX-1:0] word,
                                                  input int unsigned w);
        return W_MAX'((word >> w) & half_mask(w));
    endfunction

    // Build a 2*w word from x (low) and y (high).
    function automatic logic [2*W_MAX-1:0] pack_xy(input logic [W_MAX-1:0] x,
                                                   input logic [W_MAX-1:0] y,
                                                   input int unsigned w);
        return (((2*W_MAX)'(y) << w) | ((2*W_MAX)'(x) & half_mask(w)));
    endfunction

endpackage

// File: rtl/stitch_pipe_stage.sv
// One valid/ready-gated register slice; an empty slice always accepts.
module stitch_pipe_stage #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [PW-1:0] data_i,
    input  logic          ready_i,
    output logic          ready_c_o,
    output logic          valid_o,
    output logic [PW-1:0] data_o
);

    logic          valid_q;
    logic [PW-1:0] data_q;

    assign ready_c_o = ~valid_q | ready_i;
    assign valid_o   = valid_q;
    assign data_o    = data_q;

    // Load from upstream whenever this slice can move; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_c_o) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

endmodule

// File: rtl/stitch_pipeline_vr.sv
// Split a 2*W word into x/y, carry it through NUM_STAGES slices, add or
// subtract before the last slice, with full valid/ready backpressure.
module stitch_pipeline_vr
    import stitch_pipe_pkg::*;
#(
    parameter  int unsigned W          = DEFAULT_W,
    parameter  int unsigned NUM_STAGES = DEFAULT_STAGES,
    localparam int unsigned CNT_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   in_data,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_flag,
    output logic [CNT_W-1:0] occupancy
);

    localparam int unsigned OPW  = 2*W + 1;  // {op, y, x}
    localparam int unsigned RESW = W + 1;    // {flag, result}

    logic [NUM_STAGES:0]   vld;              // vld[0] is the producer
    logic [NUM_STAGES+1:1] rdy;              // rdy[NUM_STAGES+1] is the consumer
    logic [OPW-1:0]        opnd [NUM_STAGES]; // opnd[0] is the producer word

    assign vld[0]            = in_valid;
    assign opnd[0]           = {in_op, in_data};
    assign rdy[NUM_STAGES+1] = out_ready;
    assign in_ready          = rdy[1];

    // Operand slices 1..NUM_STAGES-1 carry the split word unchanged.
    for (genvar i = 1; i < NUM_STAGES; i++) begin : g_opnd
        stitch_pipe_stage #(.PW(OPW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid_i   (vld[i-1]),
            .data_i    (opnd[i-1]),
            .ready_i   (rdy[i+1]),
            .ready_c_o (rdy[i]),
            .valid_o   (vld[i]),
            .data_o    (opnd[i])
        );
    end

    logic [W-1:0]    x_c;
    logic [W-1:0]    y_c;
    op_e             op_c;
    logic [RESW-1:0] res_c;
    logic [RESW-1:0] res_q;

    // Add/sub on the penultimate slice; bit W is carry-out or borrow.
    always_comb begin
        x_c   = W'(unpack_x((2*W_MAX)'(opnd[NUM_STAGES-1][2*W-1:0]), W));
        y_c   = W'(unpack_y((2*W_MAX)'(opnd[NUM_STAGES-1][2*W-1:0]), W));
        op_c  = op_e'(opnd[NUM_STAGES-1][2*W]);
        res_c = {1'b0, x_c} + {1'b0, y_c};
        if (op_c == OP_SUB) begin
            res_c = {1'b0, x_c} - {1'b0, y_c};
        end
    end

    stitch_pipe_stage #(.PW(RESW)) u_last (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (vld[NUM_STAGES-1]),
        .data_i    (res_c),
        .ready_i   (rdy[NUM_STAGES+1]),
        .ready_c_o (rdy[NUM_STAGES]),
        .valid_o   (vld[NUM_STAGES]),
        .data_o    (res_q)
    );

    assign out_valid = vld[NUM_STAGES];
    assign out_data  = res_q[W-1:0];
    assign out_flag  = res_q[W];

    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    assign in_fire   = in_valid & rdy[1];
    assign out_fire  = vld[NUM_STAGES] & out_ready;
    assign occupancy = occ_q;

    // Occupancy tracks input transfers minus output transfers.
    always_comb begin
        occ_d = occ_q;
        unique case ({in_fire, out_fire})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule
